// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   req    : fetch request valid (held until gnt)
//   addr   : fetch byte address
//   gnt    : memory accepts the request this cycle
//   rvalid : read data valid (one response per granted request)
//   rdata  : read data
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if;
    logic        req;
    logic [7:0]  addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// RV32I instruction-fetch stage. Owns the fetch PC, issues one imem request
// at a time and buffers the returned word in a one-entry output register
// that feeds the IF/ID pipeline register.
//   clk, rst_n  : clock (rising edge), async active-low reset
//   stallF      : hazard hold, buffered word is not consumed
//   redirectE   : EX-stage taken branch/jump pulse, PC_targetE is the target
//   imem        : request/response bus to instruction memory (master side)
//   insF        : fetched instruction (NOP when nothing buffered)
//   PC_currentF : address of insF, PC_nextF = PC_currentF + 4
//   validF      : insF/PC fields hold a real fetched instruction
//
// state | meaning
// IDLE  | no request outstanding; waits for a free buffer slot
// REQ   | request presented on imem, held until gnt
// WAIT  | granted, waiting for rvalid
module if_fetch_stage #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallF,
    input  logic              redirectE,
    input  logic [7:0]        PC_targetE,
    if_fetch_stage_if.master  imem,
    output logic [31:0]       insF,
    output logic [7:0]        PC_currentF,
    output logic [7:0]        PC_nextF,
    output logic              validF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  req_addr_q, req_addr_d;
    logic [31:0] ins_q, ins_d;
    logic [7:0]  pcc_q, pcc_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        consume;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= 8'h00;
            ins_q      <= 32'h0000_0000;
            pcc_q      <= 8'h00;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            ins_q      <= ins_d;
            pcc_q      <= pcc_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign consume = valid_q & ~stallF;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        ins_d      = ins_q;
        pcc_d      = pcc_q;
        valid_d    = valid_q & ~consume;
        drop_d     = drop_q;

        case (state_q)
            IDLE: begin
                // A request is only launched once the buffer slot is free
                // (empty, or being consumed at this edge), so a response
                // always lands in an empty buffer.
                if (!redirectE && (!valid_q || !stallF)) begin
                    state_d    = REQ;
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 8'd4;
                end
            end
            REQ: begin
                // The request is never withdrawn; a redirect only marks the
                // eventual response as stale.
                if (imem.gnt) begin
                    state_d = WAIT;
                end
                if (redirectE) begin
                    drop_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    state_d = IDLE;
                    if (redirectE || drop_q) begin
                        drop_d = 1'b0;
                    end else begin
                        ins_d   = imem.rdata;
                        pcc_d   = req_addr_q;
                        valid_d = 1'b1;
                    end
                end else if (redirectE) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect beats both stall and consume: the buffered word belongs
        // to the wrong path and the fetch pointer jumps to the target.
        if (redirectE) begin
            pc_d    = PC_targetE;
            valid_d = 1'b0;
        end
    end

    assign imem.req  = (state_q == REQ);
    assign imem.addr = req_addr_q;

    assign validF      = valid_q;
    assign insF        = valid_q ? ins_q : NOP_INS;
    assign PC_currentF = valid_q ? pcc_q : 8'h00;
    assign PC_nextF    = valid_q ? (pcc_q + 8'd4) : 8'h00;

endmodule
